// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, IF/ID state encoding and field positions
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ifid_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h00000000;
  localparam int          REG_W       = 5;
  localparam int          RS_LSB      = 21;
  localparam int          RT_LSB      = 16;

endpackage

// File: rtl/loaduse_detect.sv
// rtl/loaduse_detect.sv - load-use hazard compare between ID/EX load target and IF/ID sources
module loaduse_detect
  import cpu_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             ifid_valid,
  output logic             hazard
);

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign hazard = idex_memread & (idex_rt != '0) & ifid_valid &
                  ((idex_rt == rs) | (idex_rt == rt));

endmodule

// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - IF/ID pipeline register with load-use stall, flush, interrupt entry and stall counter
module ifid_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCplusout,
  input  logic [31:0]      Instruct,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             Flush,
  input  logic             IRQ,
  output logic             datahazard,
  output logic [31:0]      IFID_Instruct,
  output logic [31:0]      IFID_PCplus,
  output logic             IFID_Valid,
  output logic             IRQ_take,
  output logic [CNT_W-1:0] StallCount
);

  ifid_state_t      state_q, state_d;
  logic             hazard;
  logic             irq_pend;
  logic [REG_W-1:0] rs, rt;

  assign rs = IFID_Instruct[RS_LSB +: REG_W];
  assign rt = IFID_Instruct[RT_LSB +: REG_W];

  loaduse_detect u_detect (
    .idex_memread (IDEX_MemRead),
    .idex_rt      (IDEX_Rt),
    .rs           (rs),
    .rt           (rt),
    .ifid_valid   (IFID_Valid),
    .hazard       (hazard)
  );

  // a resolved branch/jump outranks the stall: the dependent instruction is killed anyway
  assign datahazard = hazard & ~Flush;
  assign IRQ_take   = irq_pend & ~Flush & ~datahazard & (state_q == ST_RUN);

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (Flush)       state_d = ST_FLUSH;
        else if (hazard) state_d = ST_STALL;
        else             state_d = ST_RUN;
      end
      ST_FLUSH: state_d = Flush ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      IFID_Instruct <= NOP_WORD;
      IFID_PCplus   <= 32'h00000000;
      IFID_Valid    <= 1'b0;
      irq_pend      <= 1'b0;
      StallCount    <= '0;
    end else begin
      state_q <= state_d;

      // interrupt entry replaces the fetched word with a bubble, keeping PC+4 for the return address
      if (Flush || IRQ_take) begin
        IFID_Instruct <= NOP_WORD;
        IFID_Valid    <= 1'b0;
        IFID_PCplus   <= PCplusout;
      end else if (!datahazard) begin
        IFID_Instruct <= Instruct;
        IFID_Valid    <= 1'b1;
        IFID_PCplus   <= PCplusout;
      end

      // clearing wins over a still-high IRQ so acceptance can never repeat on back-to-back cycles
      irq_pend <= IRQ_take ? 1'b0 : (irq_pend | IRQ);

      if (datahazard && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_stage.sv
// tb/tb_ifid_stage.sv - randomized self-checking bench for ifid_stage against a rule-level model
module tb_ifid_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCplusout, Instruct;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        Flush, IRQ;
  logic        datahazard, IFID_Valid, IRQ_take;
  logic [31:0] IFID_Instruct, IFID_PCplus;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  // model: pipeline register contents, pending interrupt, counter, and whether the last edge was quiet
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_pend, m_quiet;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  ifid_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PCplusout     (PCplusout),
    .Instruct      (Instruct),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_Rt       (IDEX_Rt),
    .Flush         (Flush),
    .IRQ           (IRQ),
    .datahazard    (datahazard),
    .IFID_Instruct (IFID_Instruct),
    .IFID_PCplus   (IFID_PCplus),
    .IFID_Valid    (IFID_Valid),
    .IRQ_take      (IRQ_take),
    .StallCount    (StallCount)
  );

  function automatic logic exp_h();
    logic [4:0] f_rs, f_rt;
    f_rs = m_instr[25:21];
    f_rt = m_instr[20:16];
    return IDEX_MemRead && (IDEX_Rt != 5'd0) && m_valid && (IDEX_Rt == f_rs || IDEX_Rt == f_rt);
  endfunction

  function automatic logic exp_dh();
    return exp_h() && !Flush;
  endfunction

  // interrupt entry is only allowed when the previous edge saw neither a flush nor a hazard
  function automatic logic exp_take();
    return m_pend && !Flush && !exp_dh() && m_quiet;
  endfunction

  task automatic model_reset();
    m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
    m_pend = 1'b0; m_cnt = 16'h0; m_quiet = 1'b1;
  endtask

  task automatic tick();
    logic h, dh, tk;
    h = exp_h(); dh = exp_dh(); tk = exp_take();
    if (Flush || tk) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc = PCplusout;
    end else if (!dh) begin
      m_instr = Instruct; m_valid = 1'b1; m_pc = PCplusout;
    end
    m_pend  = tk ? 1'b0 : (m_pend | IRQ);
    if (dh && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_quiet = !Flush && !h;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] rtv,
                       input logic fl, input logic irq);
    Instruct = ins; IDEX_MemRead = mr; IDEX_Rt = rtv; Flush = fl; IRQ = irq;
    PCplusout = PCplusout + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCplusout = 32'h0040_0000; Instruct = 32'h1234_5678;
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; Flush = 1'b0; IRQ = 1'b0;
    #2;
    checks++;
    if (IFID_Instruct !== 32'h0 || IFID_PCplus !== 32'h0 || IFID_Valid !== 1'b0 ||
        StallCount !== 16'h0 || datahazard !== 1'b0 || IRQ_take !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got instr=%h pc=%h v=%b cnt=%h dh=%b take=%b want all zero",
               IFID_Instruct, IFID_PCplus, IFID_Valid, StallCount, datahazard, IRQ_take);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    drive(32'h2108_0001, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (IFID_Instruct !== 32'h2108_0001 || IFID_Valid !== 1'b1 || IFID_PCplus !== m_pc) begin
      errors++;
      $display("FAIL first_load got instr=%h v=%b pc=%h want %h 1 %h",
               IFID_Instruct, IFID_Valid, IFID_PCplus, 32'h2108_0001, m_pc);
    end
  endtask

  task automatic test_loaduse();
    logic [4:0] rt_tab [4] = '{5'd4, 5'd8, 5'd0, 5'd5};
    logic       hz_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] cnt0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8C88_0000, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      cnt0 = StallCount;
      drive(32'h0000_0020 + i, 1'b1, rt_tab[i], 1'b0, 1'b0);
      checks++;
      if (datahazard !== hz_tab[i]) begin
        errors++;
        $display("FAIL loaduse_dh rt=%0d got %b want %b", rt_tab[i], datahazard, hz_tab[i]);
      end
      tick();
      checks++;
      if (hz_tab[i] && (IFID_Instruct !== 32'h8C88_0000 || StallCount !== cnt0 + 16'd1)) begin
        errors++;
        $display("FAIL loaduse_hold rt=%0d got instr=%h cnt=%h want 8c880000 %h",
                 rt_tab[i], IFID_Instruct, StallCount, cnt0 + 16'd1);
      end else if (!hz_tab[i] && (IFID_Instruct !== 32'h0000_0020 + i || StallCount !== cnt0)) begin
        errors++;
        $display("FAIL loaduse_nostall rt=%0d got instr=%h cnt=%h want %h %h",
                 rt_tab[i], IFID_Instruct, StallCount, 32'h0000_0020 + i, cnt0);
      end
      drive(32'h0000_0040 + i, 1'b0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (datahazard !== 1'b0) begin
        errors++;
        $display("FAIL loaduse_release got dh=%b want 0", datahazard);
      end
      tick();
      checks++;
      if (IFID_Instruct !== 32'h0000_0040 + i || IFID_Valid !== 1'b1) begin
        errors++;
        $display("FAIL loaduse_resume got instr=%h v=%b want %h 1",
                 IFID_Instruct, IFID_Valid, 32'h0000_0040 + i);
      end
    end
  endtask

  task automatic test_flush_hazard();
    logic [15:0] cnt0;
    drive(32'h8C88_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    cnt0 = StallCount;
    drive(32'h1111_1111, 1'b1, 5'd4, 1'b1, 1'b0);
    checks++;
    if (datahazard !== 1'b0) begin
      errors++;
      $display("FAIL flush_hazard_dh got %b want 0", datahazard);
    end
    tick();
    checks++;
    if (IFID_Instruct !== 32'h0 || IFID_Valid !== 1'b0 || StallCount !== cnt0 || IFID_PCplus !== m_pc) begin
      errors++;
      $display("FAIL flush_hazard_regs got instr=%h v=%b cnt=%h pc=%h want 0 0 %h %h",
               IFID_Instruct, IFID_Valid, StallCount, IFID_PCplus, cnt0, m_pc);
    end
  endtask

  task automatic test_irq_stall();
    drive(32'h8C88_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0100, 1'b1, 5'd4, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0100, 1'b0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (IRQ_take !== 1'b0) begin
      errors++;
      $display("FAIL irq_in_stall got take=%b want 0", IRQ_take);
    end
    tick();
    drive(32'h0000_0104, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (IRQ_take !== 1'b1) begin
      errors++;
      $display("FAIL irq_first_run got take=%b want 1", IRQ_take);
    end
    tick();
    checks++;
    if (IFID_Valid !== 1'b0 || IFID_Instruct !== 32'h0) begin
      errors++;
      $display("FAIL irq_bubble got v=%b instr=%h want 0 0", IFID_Valid, IFID_Instruct);
    end
    drive(32'h0000_0108, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (IRQ_take !== 1'b0) begin
      errors++;
      $display("FAIL irq_cleared got take=%b want 0", IRQ_take);
    end
    tick();
  endtask

  task automatic test_irq_held();
    for (int i = 0; i < 8; i++) begin
      drive(32'h0000_0200 + i, 1'b0, 5'd0, 1'b0, 1'b1);
      checks++;
      if (IRQ_take !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL irq_held cyc=%0d got take=%b want %b", i, IRQ_take, (i % 2) == 1);
      end
      tick();
    end
    drive(32'h0000_0300, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0304, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_midrun();
    drive(32'h8C88_0000, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    drive(32'h0000_0400, 1'b1, 5'd4, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (IFID_Instruct !== 32'h0 || IFID_PCplus !== 32'h0 || IFID_Valid !== 1'b0 ||
        StallCount !== 16'h0 || datahazard !== 1'b0 || IRQ_take !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got instr=%h pc=%h v=%b cnt=%h dh=%b take=%b want all zero",
               IFID_Instruct, IFID_PCplus, IFID_Valid, StallCount, datahazard, IRQ_take);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    drive(32'h0000_0500, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (IRQ_take !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq_discard got take=%b want 0", IRQ_take);
    end
    tick();
    checks++;
    if (IFID_Instruct !== 32'h0000_0500 || IFID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload got instr=%h v=%b want 00000500 1", IFID_Instruct, IFID_Valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      drive(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      checks++;
      if (datahazard !== exp_dh() || IRQ_take !== exp_take()) begin
        errors++;
        $display("FAIL random_comb cyc=%0d got dh=%b take=%b want %b %b",
                 i, datahazard, IRQ_take, exp_dh(), exp_take());
      end
      tick();
      checks++;
      if (IFID_Instruct !== m_instr || IFID_PCplus !== m_pc || IFID_Valid !== m_valid || StallCount !== m_cnt) begin
        errors++;
        $display("FAIL random_regs cyc=%0d got %h %h %b %h want %h %h %b %h", i,
                 IFID_Instruct, IFID_PCplus, IFID_Valid, StallCount, m_instr, m_pc, m_valid, m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    drive(32'h8C88_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0600, 1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (datahazard !== 1'b1 || StallCount !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate got dh=%b cnt=%h want 1 ffff", datahazard, StallCount);
    end
    drive(32'h0000_0604, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (StallCount !== 16'hFFFF || IFID_Instruct !== 32'h0000_0604) begin
      errors++;
      $display("FAIL saturate_hold got cnt=%h instr=%h want ffff 00000604", StallCount, IFID_Instruct);
    end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_flush_hazard();
    test_irq_stall();
    test_irq_held();
    test_random();
    test_reset_midrun();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
